// File: rtl/mem_access_pkg.sv
// Shared constants, types and helpers for the memory-access pipeline stage.
package mem_access_pkg;

  localparam int DEF_RADDR_WIDTH = 5;
  localparam int DEF_RDATA_WIDTH = 32;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  localparam logic [1:0] MA_IDLE = 2'b00;
  localparam logic [1:0] MA_BUSY = 2'b01;
  localparam logic [1:0] MA_DONE = 2'b10;

  localparam logic [DEF_RADDR_WIDTH-1:0] ZERO_REG = '0;
  localparam logic [DEF_RDATA_WIDTH-1:0] ZERO = '0;
  localparam logic WRITE_DISABLE = 1'b0;

  // Everything about an access that must stay stable while the request is outstanding.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] sdata;
    logic        load;
  } access_t;

  // Size code 11 falls into the word case.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_SIZE_B: mis = 1'b0;
      MEM_SIZE_H: mis = off[0];
      default:    mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane formatter: byte enables and replicated store data,
// plus shifted and sign/zero-extended load data.
module mem_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr, 3'b000};
    be      = 4'b1111;
    wdata   = sdata;
    ldata   = shifted;
    case (size)
      MEM_SIZE_B: begin
        be    = 4'b0001 << addr;
        wdata = {4{sdata[7:0]}};
        ldata = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      MEM_SIZE_H: begin
        be    = 4'b0011 << {addr[1], 1'b0};
        wdata = {2{sdata[15:0]}};
        ldata = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be    = 4'b1111;
        wdata = sdata;
        ldata = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs loads/stores over a req/ack data port,
// stalls upstream while busy and passes ALU results straight through otherwise.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int RADDR_WIDTH = DEF_RADDR_WIDTH,
  parameter int RDATA_WIDTH = DEF_RDATA_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  input  logic                   mem_rd_i,
  input  logic                   mem_wr_i,
  input  logic [1:0]             mem_size_i,
  input  logic                   mem_unsigned_i,
  input  logic [RDATA_WIDTH-1:0] mem_sdata_i,
  output logic                   dmem_req_o,
  output logic                   dmem_we_o,
  output logic [31:0]            dmem_addr_o,
  output logic [3:0]             dmem_be_o,
  output logic [31:0]            dmem_wdata_o,
  input  logic                   dmem_ack_i,
  input  logic [31:0]            dmem_rdata_i,
  output logic                   stall_o,
  output logic                   misalign_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o
);

  logic [1:0]             state;
  access_t                acc_q;
  logic [RADDR_WIDTH-1:0] waddr_q;
  logic                   we_q;
  logic                   err_q;
  logic [31:0]            ldata_q;

  logic                   is_mem;
  logic                   mis_now;
  logic [31:0]            eff_addr;
  logic [3:0]             align_be;
  logic [31:0]            align_wdata;
  logic [31:0]            align_ldata;

  assign is_mem   = mem_rd_i | mem_wr_i;
  assign eff_addr = 32'(reg_wdata_i);
  assign mis_now  = is_misaligned(mem_size_i, eff_addr[1:0]);

  // The formatter only ever sees captured fields, so the bus stays stable until ack.
  mem_align u_align (
    .addr        (acc_q.addr[1:0]),
    .size        (acc_q.size),
    .is_unsigned (acc_q.is_unsigned),
    .sdata       (acc_q.sdata),
    .rdata       (dmem_rdata_i),
    .be          (align_be),
    .wdata       (align_wdata),
    .ldata       (align_ldata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= MA_IDLE;
      acc_q   <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      ldata_q <= '0;
    end else begin
      case (state)
        MA_IDLE: begin
          if (is_mem) begin
            acc_q.addr        <= eff_addr;
            acc_q.size        <= mem_size_i;
            acc_q.is_unsigned <= mem_unsigned_i;
            acc_q.sdata       <= 32'(mem_sdata_i);
            acc_q.load        <= mem_rd_i;
            waddr_q           <= reg_waddr_i;
            we_q              <= reg_we_i;
            err_q             <= mis_now;
            ldata_q           <= '0;
            state             <= mis_now ? MA_DONE : MA_BUSY;
          end
        end
        MA_BUSY: begin
          if (dmem_ack_i) begin
            ldata_q <= align_ldata;
            state   <= MA_DONE;
          end
        end
        MA_DONE: state <= MA_IDLE;
        default: state <= MA_IDLE;
      endcase
    end
  end

  // Reset forces every output low, including the combinational pass-through.
  always_comb begin
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = ZERO;
    dmem_be_o    = 4'b0000;
    dmem_wdata_o = ZERO;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    reg_waddr_o  = RADDR_WIDTH'(ZERO_REG);
    reg_we_o     = WRITE_DISABLE;
    reg_wdata_o  = RDATA_WIDTH'(ZERO);
    if (!rst_i) begin
      case (state)
        MA_IDLE: begin
          reg_waddr_o = reg_waddr_i;
          reg_wdata_o = reg_wdata_i;
          if (is_mem) begin
            stall_o  = 1'b1;
            reg_we_o = WRITE_DISABLE;
          end else begin
            reg_we_o = reg_we_i;
          end
        end
        MA_BUSY: begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = ~acc_q.load;
          dmem_addr_o  = {acc_q.addr[31:2], 2'b00};
          dmem_be_o    = align_be;
          dmem_wdata_o = align_wdata;
          stall_o      = 1'b1;
        end
        MA_DONE: begin
          reg_waddr_o = waddr_q;
          reg_wdata_o = RDATA_WIDTH'(ldata_q);
          reg_we_o    = we_q & acc_q.load & ~err_q;
          misalign_o  = err_q;
        end
        default: begin
          stall_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage RISC-V core. It sits between ex_mem and mem_wb, and executes loads and stores against the data-memory port using a req/ack handshake. It stalls the upstream pipeline while an access is outstanding. Non-memory instructions pass straight through to mem_wb in the same cycle.

## Interface
- RADDR_WIDTH, 5, register-address width (`RADDR_WIDTH)
- RDATA_WIDTH, 32, register/data width (`RDATA_WIDTH)

- clk_i  in  1  clock; every register updates on the rising edge
- rst_i  in  1  reset, synchronous and active-high
- reg_waddr_i  in  RADDR_WIDTH  destination register, from ex_mem
- reg_we_i  in  1  register write enable, from ex_mem
- reg_wdata_i  in  RDATA_WIDTH  ALU result; this is the effective address for loads and stores
- mem_rd_i  in  1  instruction is a load
- mem_wr_i  in  1  instruction is a store
- mem_size_i  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word
- mem_unsigned_i  in  1  zero-extend the load result (LBU/LHU)
- mem_sdata_i  in  RDATA_WIDTH  store data (rs2)
- dmem_req_o  out  1  memory request valid
- dmem_we_o  out  1  request is a store
- dmem_addr_o  out  32  word-aligned address ({addr[31:2], 2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned store data
- dmem_ack_i  in  1  request accepted; rdata is valid in the same cycle
- dmem_rdata_i  in  32  load word
- stall_o  out  1  hold ex_mem and all earlier stages
- misalign_o  out  1  one-cycle pulse on a misaligned access
- reg_waddr_o  out  RADDR_WIDTH  to mem_wb
- reg_we_o  out  1  to mem_wb
- reg_wdata_o  out  RDATA_WIDTH  to mem_wb

## Operation
- **Reset values.** While rst_i=1, every output is 0: reg_* outputs, dmem_* outputs, stall_o and misalign_o. Reset puts the FSM in IDLE.
- **FSM states.** IDLE, BUSY, DONE.
- **IDLE, no memory operation** (mem_rd_i=0 and mem_wr_i=0):
  - reg_* outputs are a combinational pass-through of reg_*_i.
  - stall_o=0.
- **IDLE, memory operation:**
  - The FSM captures address, size, unsigned flag, store data, waddr, we and the op kind into internal registers.
  - stall_o=1 combinationally, and reg_we_o=0 (bubble).
  - Aligned access: go to BUSY.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0): go to DONE with an error flag set. No memory request is issued.
- **Both mem_rd_i and mem_wr_i set.** Treated as a load.
- **BUSY:**
  - dmem_req_o=1. Address, we, be and wdata come only from the captured registers and stay stable until ack.
  - stall_o=1 and reg_we_o=0.
  - When dmem_ack_i=1: capture the formatted load data and go to DONE.
- **DONE:**
  - reg_waddr_o = captured waddr.
  - reg_wdata_o = formatted load data.
  - reg_we_o = captured we, only for a load with no error; otherwise 0.
  - misalign_o = error flag.
  - stall_o=0.
  - Inputs are ignored because ex_mem still shows the same instruction.
  - Next state is always IDLE.
- **Store formatting:**
  - byte: be = 4'b0001 << addr[1:0]; wdata = sdata[7:0] replicated 4 times.
  - half: be = 4'b0011 << {addr[1],1'b0}; wdata = sdata[15:0] replicated 2 times.
  - word: be = 4'b1111; wdata = sdata.
- **Load formatting:** shift dmem_rdata_i right by addr[1:0]*8, then sign- or zero-extend from bit 7 (byte) or bit 15 (half). Word loads are not extended.
- **Loads during request.** dmem_we_o=0 and dmem_be_o still indicate the accessed lanes.
- **dmem_ack_i outside BUSY.** Ignored.
- **Reset during BUSY.** dmem_req_o drops in the next cycle, the FSM returns to IDLE, and the access is abandoned.
- **Stores.** A store never writes the register file.

## Timing
- Non-memory instruction: 0-cycle latency, combinational.
- Memory instruction, ack in the first BUSY cycle: 3 cycles (IDLE, BUSY, DONE), with stall_o high for 2 cycles.
- Each extra wait cycle on dmem_ack_i adds one BUSY cycle.
- Misaligned access: 2 cycles (IDLE, DONE), with stall_o high for 1 cycle. misalign_o is high in the DONE cycle only.
- Handshake: once dmem_req_o rises, it stays high until the cycle in which dmem_ack_i=1, inclusive.

## Structure
- Additions to defines.v:
  - `MEM_SIZE_B` / `MEM_SIZE_H` / `MEM_SIZE_W`
  - 2-bit state encodings `MA_IDLE` / `MA_BUSY` / `MA_DONE`
  - reuse of `ZERO_REG`, `ZERO` and `WRITE_DISABLE`
- Sub-module mem_align: purely combinational lane formatter. Inputs are addr[1:0], size, unsigned, sdata and rdata. Outputs are be, wdata and the extended load data. It is instantiated once.

## Test plan
- **ALU pass-through.** Non-memory op with waddr=5, we=1, wdata=0x1234: reg_*_o mirror the inputs in the same cycle and stall_o=0.
- **LB, ack in the first BUSY cycle.** Address 0x103, rdata=0x80FF_FF00: dmem_addr_o=0x100, be=1000, stall_o high for 2 cycles, DONE gives wdata=0xFFFF_FF80 with we=1. The same access as LBU gives 0x0000_0080.
- **SH, ack after 3 wait cycles.** Address 0x22, sdata=0xABCD_5678: be=1100, wdata=0x5678_5678, req held stable for 4 cycles, stall_o high for 5 cycles, reg_we_o=0 in DONE.
- **Misaligned LW.** Address 0x41: dmem_req_o never rises, misalign_o pulses 1 cycle, reg_we_o=0.
- **Reset in the 2nd BUSY cycle.** Next cycle: all outputs are 0 and the FSM is in IDLE. A later ack is ignored and a new LW to 0x0 with ack completes normally.
